sqrt_share_ctrl: RTL

Sequential square-root service unit that shares one iterative integer square-root engine among NUM_REQ requesters. It arbitrates round-robin among valid requests, latches the winning operand, and resolves one root bit per cycle by bisection. It returns floor(sqrt(x)), the remainder and the requester ID over a valid/ready response port. It sits between the block's requesting datapaths and replaces per-requester combinational square-root logic.

---
 rtl/sqrt_share_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/sqrt_share_ctrl.sv
// Shared iterative integer square-root engine: round-robin arbitration among
// NUM_REQ requesters, one root bit per cycle, result returned over valid/ready.
module sqrt_share_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    localparam int R      = WIDTH / 2,
    localparam int RW     = R + 1,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int BW     = (R > 1) ? $clog2(R) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [R-1:0]             rsp_root,
    output logic [RW-1:0]            rsp_rem,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_reg, state_next;
    logic [ID_W-1:0]   last_reg, id_reg, grant_idx;
    logic              grant_found, accept;
    logic [WIDTH-1:0]  x_reg, grant_data, trial_sq;
    logic [R-1:0]      root_reg, one_hot, trial, root_calc;
    logic [BW-1:0]     bit_reg;
    logic [RW-1:0]     rem_reg, rem_calc;

    // Search order starts just after the last winner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!grant_found && req_valid[(int'(last_reg) + k) % NUM_REQ]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'((int'(last_reg) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                grant_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // rst_n gates ready so nothing is offered while reset is held.
    assign accept = rst_n && (state_reg == IDLE) && grant_found;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = accept && (grant_idx == ID_W'(gi));
        end
    endgenerate

    // Bisection step; the remainder fits in R+1 bits, so modular arithmetic at that width is exact.
    assign one_hot   = R'(1) << bit_reg;
    assign trial     = root_reg | one_hot;
    assign trial_sq  = WIDTH'(trial) * WIDTH'(trial);
    assign root_calc = (trial_sq <= x_reg) ? trial : root_reg;
    assign rem_calc  = x_reg[RW-1:0] - (RW'(root_calc) * RW'(root_calc));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (bit_reg == '0) state_next = DONE;
            DONE:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            last_reg  <= ID_W'(NUM_REQ - 1);
            id_reg    <= '0;
            x_reg     <= '0;
            root_reg  <= '0;
            bit_reg   <= '0;
            rem_reg   <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        x_reg    <= grant_data;
                        id_reg   <= grant_idx;
                        last_reg <= grant_idx;
                        root_reg <= '0;
                        bit_reg  <= BW'(R - 1);
                    end
                end
                CALC: begin
                    root_reg <= root_calc;
                    bit_reg  <= bit_reg - BW'(1);
                    if (bit_reg == '0) rem_reg <= rem_calc;
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign rsp_id    = id_reg;
    assign rsp_root  = root_reg;
    assign rsp_rem   = rem_reg;

endmodule
